// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences MULT/MULTU/DIV/DIVU and stalls EX while busy.
// Optional MDU_DIV0_FLAG_EN adds div0_o and leaves HI/LO untouched on divide-by-zero.
module mdu_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] srca_i,
  input  logic [31:0] srcb_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic        div0_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [1:0]  op_reg;
  logic [31:0] a_reg, b_reg;
  logic [31:0] quo_reg, rem_reg, bmag_reg;
  logic        load, div_step, wr_res, wr_hi, wr_lo;

  // Operand magnitudes captured at issue; the divider only ever sees unsigned values.
  logic        signed_in;
  logic [31:0] amag_in, bmag_in;
  assign signed_in = ~op_i[0];
  assign amag_in   = (signed_in && srca_i[31]) ? -srca_i : srca_i;
  assign bmag_in   = (signed_in && srcb_i[31]) ? -srcb_i : srcb_i;

  // Multiplier: 33-bit extended operands give one product path for signed and unsigned.
  logic [32:0] mul_a, mul_b;
  logic [63:0] mul_full;
  assign mul_a    = {~op_reg[0] & a_reg[31], a_reg};
  assign mul_b    = {~op_reg[0] & b_reg[31], b_reg};
  assign mul_full = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_mul_stage
      logic [63:0] stage_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) stage_q <= mul_full;
      end else begin : g_next
        always_ff @(posedge clk) stage_q <= g_mul_stage[gi-1].stage_q;
      end
    end
  endgenerate

  logic [63:0] product;
  assign product = g_mul_stage[MUL_LAT-1].stage_q;

  // Restoring divider step: dividend bits shift out of quo_reg as quotient bits shift in.
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  assign rem_shift = {rem_reg, quo_reg[31]};
  assign rem_ge    = rem_shift >= {1'b0, bmag_reg};
  assign rem_sub   = rem_shift[31:0] - bmag_reg;

  logic        neg_q, neg_r;
  logic [31:0] res_hi, res_lo;
  assign neg_q = ~op_reg[0] & (a_reg[31] ^ b_reg[31]);
  assign neg_r = ~op_reg[0] & a_reg[31];

  always_comb begin
    res_hi = product[63:32];
    res_lo = product[31:0];
    if (op_reg[1]) begin
      if (b_reg == '0) begin
        res_hi = a_reg;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -rem_reg : rem_reg;
        res_lo = neg_q ? -quo_reg : quo_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_o    = 1'b0;
    load       = 1'b0;
    div_step   = 1'b0;
    wr_res     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!flush_i) begin
          if (start_i) begin
            load       = 1'b1;
            stall_o    = 1'b1;
            state_next = op_i[1] ? DIV : MUL;
            cnt_next   = op_i[1] ? 5'd31 : 5'(MUL_LAT - 1);
          end else begin
            wr_hi = mthi_i;
            wr_lo = mtlo_i;
          end
        end
      end
      MUL, DIV: begin
        if (flush_i) begin
          state_next = IDLE;
        end else begin
          stall_o  = 1'b1;
          div_step = (state_reg == DIV);
          if (cnt_reg == 5'd0) state_next = DONE;
          else                 cnt_next   = cnt_reg - 5'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        wr_res     = !flush_i;
`ifdef MDU_DIV0_FLAG_EN
        if (op_reg[1] && b_reg == '0) wr_res = 1'b0;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      bmag_reg  <= '0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        op_reg   <= op_i;
        a_reg    <= srca_i;
        b_reg    <= srcb_i;
        quo_reg  <= amag_in;
        rem_reg  <= '0;
        bmag_reg <= bmag_in;
      end else if (div_step) begin
        quo_reg <= {quo_reg[30:0], rem_ge};
        rem_reg <= rem_ge ? rem_sub : rem_shift[31:0];
      end
      if (wr_res) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end else begin
        if (wr_hi) hi_o <= wdata_i;
        if (wr_lo) lo_o <= wdata_i;
      end
    end
  end

  assign busy_o = (state_reg != IDLE);

`ifdef MDU_DIV0_FLAG_EN
  assign div0_o = (state_reg == DONE) && op_reg[1] && (b_reg == '0);
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops against an arithmetic model.
module tb_mdu_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, flush_i, start_i, mthi_i, mtlo_i;
  logic [1:0]  op_i;
  logic [31:0] srca_i, srcb_i, wdata_i;
  logic        stall_o, busy_o;
  logic [31:0] hi_o, lo_o;
`ifdef MDU_DIV0_FLAG_EN
  logic        div0_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] hi_m, lo_m;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i), .op_i(op_i),
    .srca_i(srca_i), .srcb_i(srcb_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
    .wdata_i(wdata_i), .stall_o(stall_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
`ifdef MDU_DIV0_FLAG_EN
    , .div0_o(div0_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // {HI, LO} as the architecture defines them, from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00:   res = 64'(sa * sb);
      2'b01:   res = ua * ub;
      2'b10:   res = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: res = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
    endcase
    return res;
  endfunction

  // Entered and left just after a rising edge; issues one op and follows it through DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit drop_mt, input string tag);
    int          n, exp_n;
    logic [63:0] r;
    r = model(op, a, b);
`ifdef MDU_DIV0_FLAG_EN
    if (op[1] && b == 0) r = {hi_m, lo_m};
`endif
    exp_n   = op[1] ? 33 : 1 + MUL_LAT;
    start_i = 1'b1; op_i = op; srca_i = a; srcb_i = b;
    mtlo_i  = drop_mt; wdata_i = 32'hDEADBEEF;
    n = 0;
    @(negedge clk);
    while (stall_o === 1'b1 && n < 64) begin
      n++;
      @(posedge clk); #1;
      start_i = 1'b0; mtlo_i = 1'b0;
      if (n == 1 && drop_mt) check({tag, " mt dropped"}, lo_o, lo_m);
      @(negedge clk);
    end
    check({tag, " stall cycles"}, 32'(n), 32'(exp_n));
    check({tag, " busy in done"}, {31'b0, busy_o}, 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0; mtlo_i = 1'b0;
    hi_m = r[63:32];
    lo_m = r[31:0];
    check({tag, " hi"}, hi_o, hi_m);
    check({tag, " lo"}, lo_o, lo_m);
    check({tag, " idle after"}, {31'b0, busy_o}, 32'd0);
    $display("%s: op=%0d a=%h b=%h -> hi=%h lo=%h stall=%0d", tag, op, a, b, hi_o, lo_o, n);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
    op_i = '0; srca_i = '0; srcb_i = '0; wdata_i = '0;
    hi_m = '0; lo_m = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset hi", hi_o, 32'h0);
    check("reset lo", lo_o, 32'h0);
    check("reset busy", {31'b0, busy_o}, 32'd0);
    check("reset stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 1'b0, "MULT -2x3");
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "MULTU max");
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, "DIV -7/2");
    run_op(2'b11, 32'h00000007, 32'h00000002, 1'b0, "DIVU 7/2");
    run_op(2'b11, 32'h00001234, 32'h00000000, 1'b0, "DIVU by 0");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "DIV min/-1");

    mthi_i = 1'b1; wdata_i = 32'h12345678;
    @(posedge clk); #1;
    mthi_i = 1'b0; hi_m = 32'h12345678;
    check("mthi hi", hi_o, hi_m);
    check("mthi lo kept", lo_o, lo_m);
    $display("MTHI: hi=%h", hi_o);

    mtlo_i = 1'b1; wdata_i = 32'h0BADF00D;
    @(posedge clk); #1;
    mtlo_i = 1'b0; lo_m = 32'h0BADF00D;
    check("mtlo lo", lo_o, lo_m);
    $display("MTLO: lo=%h", lo_o);

    run_op(2'b01, 32'h00000002, 32'h00000003, 1'b1, "MULTU with mtlo");

    mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hAAAAAAAA;
    @(posedge clk); #1;
    mthi_i = 1'b0; mtlo_i = 1'b0; hi_m = 32'hAAAAAAAA; lo_m = 32'hAAAAAAAA;
    check("mthi+mtlo hi", hi_o, hi_m);
    check("mthi+mtlo lo", lo_o, lo_m);
    $display("MTHI+MTLO: hi=%h lo=%h", hi_o, lo_o);

    // Abort a divide on its 10th cycle in DIV.
    start_i = 1'b1; op_i = 2'b10; srca_i = 32'd1000; srcb_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    check("flush stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush idle", {31'b0, busy_o}, 32'd0);
    check("flush hi kept", hi_o, hi_m);
    check("flush lo kept", lo_o, lo_m);
    $display("FLUSH DIV: hi=%h lo=%h busy=%0d", hi_o, lo_o, busy_o);

    run_op(2'b01, 32'd5, 32'd6, 1'b0, "MULTU 5x6 after flush");

    // Flush in IDLE must swallow a simultaneous start.
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b11; srca_i = 32'd9; srcb_i = 32'd4;
    @(negedge clk);
    check("idle flush stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("idle flush busy", {31'b0, busy_o}, 32'd0);
    check("idle flush lo", lo_o, lo_m);
    $display("FLUSH IDLE: busy=%0d lo=%h", busy_o, lo_o);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1'b0, $sformatf("rand%0d", i));
    end

    // Reset in the middle of a divide.
    start_i = 1'b1; op_i = 2'b10; srca_i = 32'h7FFF0000; srcb_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; hi_m = '0; lo_m = '0;
    @(negedge clk);
    check("rst mid-div hi", hi_o, hi_m);
    check("rst mid-div lo", lo_o, lo_m);
    check("rst mid-div busy", {31'b0, busy_o}, 32'd0);
    check("rst mid-div stall", {31'b0, stall_o}, 32'd0);
    $display("RESET MID-DIV: hi=%h lo=%h busy=%0d", hi_o, lo_o, busy_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller that sequences MULT, MULTU, DIV and DIVU for the EX stage.
- Owns the architectural HI and LO registers, and services MTHI and MTLO.
- Stalls the pipeline while an operation is in flight.
- Contains an iterative radix-2 restoring divider (32 iterations) and a multiplier with MUL_LAT register stages.

Parameters:
MUL_LAT, 2, number of multiply cycles after issue; legal range 1..8

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
flush_i  input  1  exception flush; aborts the in-flight op
start_i  input  1  an MDU op is present in EX this cycle
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca_i  input  32  rs operand (dividend / multiplicand)
srcb_i  input  32  rt operand (divisor / multiplier)
mthi_i  input  1  write wdata_i to HI
mtlo_i  input  1  write wdata_i to LO
wdata_i  input  32  MTHI/MTLO data
stall_o  output  1  freeze IF..EX
busy_o  output  1  state != IDLE
hi_o  output  32  HI register
lo_o  output  32  LO register

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, hi_o=0, lo_o=0. stall_o and busy_o are 0 from the following cycle. Reset overrides every other input in any state.
- States:
  - IDLE: idle; the only state that accepts start_i, mthi_i and mtlo_i.
  - MUL: multiply in flight.
  - DIV: divide in flight.
  - DONE: result ready; HI/LO written at its exit edge.
- IDLE with start_i=1:
  - Latch op, srca_i and srcb_i.
  - Go to MUL with counter=MUL_LAT-1, or to DIV with counter=31.
  - stall_o=1 combinationally in this same cycle.
- MUL:
  - stall_o=1.
  - Full 64-bit product, signed or unsigned per op, propagated through the stages.
  - When counter==0, go to DONE; otherwise decrement counter.
- DIV:
  - stall_o=1.
  - Operate on operand magnitudes (signed ops take the absolute value; abs(0x80000000) = 0x80000000 treated as unsigned).
  - One quotient bit per cycle.
  - When counter==0, go to DONE.
  - Sign fix-up: quotient is negated if sign(a) XOR sign(b); remainder takes the sign of a.
- DONE:
  - stall_o=0, busy_o=1.
  - At the exit edge: HI<=product[63:32] / remainder and LO<=product[31:0] / quotient. Go to IDLE.
  - start_i is ignored in DONE (the issuing instruction leaves EX at this edge).
- Latency:
  - Multiply: stall_o high for 1+MUL_LAT cycles.
  - Divide: stall_o high for 33 cycles.
  - New HI/LO is visible on hi_o/lo_o in the cycle after DONE.
- Divide by zero (srcb==0, signed or unsigned): HI=srca, LO=0xFFFFFFFF.
- flush_i in MUL, DIV or DONE:
  - Next state IDLE; HI/LO are not written.
  - stall_o is forced 0 in the flush cycle.
  - flush_i in IDLE discards a simultaneous start_i.
- mthi_i/mtlo_i: honoured only in IDLE with start_i=0 and flush_i=0; HI/LO update at the edge.
  - If start_i and mt* are asserted together (illegal), start_i wins and mt* is dropped.
  - mthi_i and mtlo_i together write both registers.
- hi_o/lo_o are direct register outputs; there is no combinational forwarding.

Optional Feature:
- Macro: MDU_DIV0_FLAG_EN.
- When defined:
  - Adds output div0_o (1 bit, reset 0).
  - div0_o is a 1-cycle pulse during DONE of a DIV/DIVU whose latched divisor is 0.
  - HI/LO are left unchanged for that operation.
- When undefined: no div0_o port; the divide-by-zero results above apply.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003 (MUL_LAT=2) -> stall_o high 3 cycles; then hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV -7 / 2 (0xFFFFFFF9, 0x2) -> stall_o high 33 cycles; lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU 7 / 2 -> lo_o=3, hi_o=1.
- DIVU 0x1234 / 0:
  - Macro undefined -> hi_o=0x1234, lo_o=0xFFFFFFFF.
  - Macro defined -> div0_o pulses 1 cycle, HI/LO unchanged.
- Flush and reset:
  - Preload HI=LO=0xAAAAAAAA, start DIV, flush_i at the 10th DIV cycle -> state IDLE next cycle, stall_o=0 in the flush cycle, hi_o/lo_o still 0xAAAAAAAA.
  - Immediate MULTU 5x6 afterwards -> lo_o=30, hi_o=0.
  - rst mid-DIV -> hi_o=lo_o=0, busy_o=0.
- MTHI/MTLO:
  - mthi_i with wdata_i=0x12345678 in IDLE -> hi_o=0x12345678 next cycle.
  - mtlo_i asserted together with start_i -> mtlo dropped, op proceeds.
